// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input conditioning block: the register
// map offsets, the debounce state encoding and a small decode helper.
package gpio_pkg;

  // Number of address bits the register decoder looks at.
  localparam int BDW = 5;

  // Register offsets within the block's address window.
  localparam logic [BDW-1:0] ADDR_DEB     = 5'h00;
  localparam logic [BDW-1:0] ADDR_RISE_EN = 5'h04;
  localparam logic [BDW-1:0] ADDR_FALL_EN = 5'h08;
  localparam logic [BDW-1:0] ADDR_STATUS  = 5'h0C;
  localparam logic [BDW-1:0] ADDR_STATE   = 5'h10;

  // Per-pin debounce state: STABLE when the synchronised input matches the
  // accepted level, PENDING while a different level is being timed.
  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } gpio_dbg_state_t;

  // True when an offset hits one of the implemented registers.
  function automatic logic addr_mapped(input logic [BDW-1:0] a);
    return (a == ADDR_DEB)     || (a == ADDR_RISE_EN) ||
           (a == ADDR_FALL_EN) || (a == ADDR_STATUS)  ||
           (a == ADDR_STATE);
  endfunction

endpackage

// File: rtl/sys_bus_if.sv
// Simple single-cycle system bus used for register access. The slave
// answers every access with ack one cycle later.
interface sys_bus_if (
  input logic clk
);
  logic        rstn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport s (
    input  clk, rstn, addr, wdata, wen, ren,
    output rdata, ack, err
  );

  modport m (
    input  clk, rdata, ack, err,
    output rstn, addr, wdata, wen, ren
  );
endinterface

// File: rtl/gpio_debounce.sv
// One pin of input conditioning: a multi-flop synchroniser followed by a
// counter-based debouncer. The accepted level q only moves after the
// synchronised input has differed from it for the programmed period.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int SW = 2,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pin,
  input  logic [CW-1:0] deb,
  output logic          q
);

  logic [SW-1:0]   sync;
  logic            s;
  logic            q_reg;
  logic            q_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [CW:0]     cnt_inc;
  logic [CW:0]     limit;
  gpio_dbg_state_t state;

  assign s = sync[SW-1];

  // Shift the raw pin through the synchroniser chain to settle metastability.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= '0;
    end else begin
      sync <= {sync[SW-2:0], pin};
    end
  end

  // State register: the accepted level and the running debounce count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_reg <= 1'b0;
      cnt   <= '0;
    end else begin
      q_reg <= q_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. The increment is one bit wider so it never wraps, and
  // the >= compare lets a lowered period take effect on the very next cycle.
  // A period of 0 behaves like 1 because cnt+1 is always at least 1.
  always_comb begin
    state    = (s == q_reg) ? STABLE : PENDING;
    cnt_inc  = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    limit    = {1'b0, deb};
    q_next   = q_reg;
    cnt_next = '0;
    case (state)
      STABLE: begin
        cnt_next = '0;
      end
      PENDING: begin
        if (cnt_inc >= limit) begin
          q_next   = s;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_inc[CW-1:0];
        end
      end
      default: begin
        cnt_next = '0;
      end
    endcase
  end

  // Output: the accepted level drives the pin's debounced state directly.
  always_comb begin
    q = q_reg;
  end

endmodule

// File: rtl/gpio_in.sv
// GPIO input stage: debounces every pin, latches enabled rising/falling
// edges in sticky status bits, raises a level interrupt and exposes the
// configuration and status registers on the system bus.
module gpio_in
  import gpio_pkg::*;
#(
  parameter int DW = 8,
  parameter int SW = 2,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] pin_i,
  output logic [DW-1:0] gpio_i,
  output logic          irq,
  sys_bus_if.s          bus
);

  logic [BDW-1:0] sel;
  logic           wr_deb;
  logic           wr_rise;
  logic           wr_fall;
  logic           wr_status;
  logic [CW-1:0]  deb_reg;
  logic [DW-1:0]  rise_en;
  logic [DW-1:0]  fall_en;
  logic [DW-1:0]  status;
  logic [DW-1:0]  status_next;
  logic [DW-1:0]  gpio_q;
  logic [DW-1:0]  rise;
  logic [DW-1:0]  fall;
  logic [DW-1:0]  clr;
  logic [31:0]    rd_mux;
  logic           unused_bits;

  assign sel = bus.addr[BDW-1:0];

  // Bus reset, clock and the undecoded upper bits are deliberately ignored.
  assign unused_bits = ^{bus.clk, bus.rstn, bus.addr, bus.wdata};

  // One debouncer per pin.
  for (genvar i = 0; i < DW; i++) begin : g_pin
    gpio_debounce #(
      .SW (SW),
      .CW (CW)
    ) u_deb (
      .clk  (clk),
      .rstn (rstn),
      .pin  (pin_i[i]),
      .deb  (deb_reg),
      .q    (gpio_i[i])
    );
  end

  // Write strobes for each implemented register.
  always_comb begin
    wr_deb    = 1'b0;
    wr_rise   = 1'b0;
    wr_fall   = 1'b0;
    wr_status = 1'b0;
    if (bus.wen) begin
      wr_deb    = (sel == ADDR_DEB);
      wr_rise   = (sel == ADDR_RISE_EN);
      wr_fall   = (sel == ADDR_FALL_EN);
      wr_status = (sel == ADDR_STATUS);
    end
  end

  // Edge events come from the debounced level versus its copy one cycle
  // older; a set takes priority over a simultaneous write-1-clear.
  always_comb begin
    rise        = ~gpio_q & gpio_i;
    fall        = gpio_q & ~gpio_i;
    clr         = wr_status ? bus.wdata[DW-1:0] : '0;
    status_next = (status & ~clr) | (rise & rise_en) | (fall & fall_en);
  end

  // Read mux; unmapped offsets return zero and all data is zero-extended.
  always_comb begin
    rd_mux = '0;
    if (addr_mapped(sel)) begin
      case (sel)
        ADDR_DEB:     rd_mux[CW-1:0] = deb_reg;
        ADDR_RISE_EN: rd_mux[DW-1:0] = rise_en;
        ADDR_FALL_EN: rd_mux[DW-1:0] = fall_en;
        ADDR_STATUS:  rd_mux[DW-1:0] = status;
        ADDR_STATE:   rd_mux[DW-1:0] = gpio_i;
        default:      rd_mux = '0;
      endcase
    end
  end

  // Configuration registers take the written value on the accepting edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deb_reg <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else begin
      if (wr_deb)  deb_reg <= bus.wdata[CW-1:0];
      if (wr_rise) rise_en <= bus.wdata[DW-1:0];
      if (wr_fall) fall_en <= bus.wdata[DW-1:0];
    end
  end

  // Sticky status, the delayed level used for edge detection, and the
  // interrupt, which tracks the next status so both change together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      status <= '0;
      gpio_q <= '0;
      irq    <= 1'b0;
    end else begin
      status <= status_next;
      gpio_q <= gpio_i;
      irq    <= |status_next;
    end
  end

  // Bus response: every access is acknowledged one cycle later, and reads
  // capture the pre-update register contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack <= bus.wen | bus.ren;
      if (bus.ren) bus.rdata <= rd_mux;
    end
  end

  assign bus.err = 1'b0;

endmodule

// File: tb/tb_gpio_in.sv
// Directed self-checking bench for gpio_in: reset state, debounce latency,
// glitch rejection, edge status, write-1-clear and asynchronous reset.
module tb_gpio_in;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int CW = 16;

  logic          clk;
  logic          rstn;
  logic [DW-1:0] pin_i;
  logic [DW-1:0] gpio_i;
  logic          irq;
  int            total;
  int            bad;

  sys_bus_if bus (.clk(clk));
  assign bus.rstn = rstn;

  gpio_in #(
    .DW (DW),
    .SW (SW),
    .CW (CW)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .pin_i  (pin_i),
    .gpio_i (gpio_i),
    .irq    (irq),
    .bus    (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single register write; returns 1 time unit after the accepting edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.addr  = a;
    bus.wdata = d;
    bus.wen   = 1'b1;
    @(posedge clk);
    #1;
    bus.wen = 1'b0;
  endtask

  // Single register read; returns captured rdata and ack.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic k);
    @(posedge clk);
    #1;
    bus.addr = a;
    bus.ren  = 1'b1;
    @(posedge clk);
    #1;
    bus.ren = 1'b0;
    d = bus.rdata;
    k = bus.ack;
  endtask

  task automatic test_reset;
    logic [31:0] addrs [6];
    logic [31:0] d;
    logic        k;
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (gpio_i !== 8'h00 || irq !== 1'b0 || bus.ack !== 1'b0 || bus.err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got gpio=%h irq=%b ack=%b err=%b expected 00 0 0 0",
               gpio_i, irq, bus.ack, bus.err);
    end
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_read(addrs[i], d, k);
      total++;
      if (d !== 32'h0 || k !== 1'b1 || bus.err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_read_%h: got data=%h ack=%b err=%b expected 0 1 0",
                 addrs[i], d, k, bus.err);
      end
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_deb0_rise;
    logic [31:0] d;
    logic        k;
    bus_write(32'h04, 32'h01);
    @(posedge clk);
    #1;
    pin_i[0] = 1'b1;
    for (int e = 1; e <= SW + 2; e++) begin
      @(posedge clk);
      #1;
      total++;
      if (gpio_i[0] !== (e >= SW + 1)) begin
        bad++;
        $display("[TB] FAIL deb0_gpio_edge%0d: got %b expected %b", e, gpio_i[0], e >= SW + 1);
      end
      total++;
      if (irq !== (e >= SW + 2)) begin
        bad++;
        $display("[TB] FAIL deb0_irq_edge%0d: got %b expected %b", e, irq, e >= SW + 2);
      end
    end
    bus_read(32'h0C, d, k);
    total++;
    if (d !== 32'h01) begin
      bad++;
      $display("[TB] FAIL deb0_status: got %h expected 00000001", d);
    end
  endtask

  task automatic test_glitch_fall;
    logic [31:0] d;
    logic        k;
    pin_i[7] = 1'b1;
    repeat (SW + 3) @(posedge clk);
    #1;
    total++;
    if (gpio_i[7] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pin7_high: got %b expected 1", gpio_i[7]);
    end
    bus_write(32'h00, 32'd10);
    bus_write(32'h08, 32'h80);
    bus_read(32'h00, d, k);
    total++;
    if (d !== 32'd10) begin
      bad++;
      $display("[TB] FAIL deb_readback: got %h expected 0000000a", d);
    end
    @(posedge clk);
    #1;
    pin_i[7] = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      @(posedge clk);
      #1;
      if (e == 9) pin_i[7] = 1'b1;
      total++;
      if (gpio_i[7] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL glitch_edge%0d: got %b expected 1", e, gpio_i[7]);
      end
    end
    @(posedge clk);
    #1;
    pin_i[7] = 1'b0;
    for (int e = 1; e <= SW + 11; e++) begin
      @(posedge clk);
      #1;
      total++;
      if (gpio_i[7] !== !(e >= SW + 10)) begin
        bad++;
        $display("[TB] FAIL fall_edge%0d: got %b expected %b", e, gpio_i[7], !(e >= SW + 10));
      end
    end
    bus_read(32'h0C, d, k);
    total++;
    if (d !== 32'h81 || irq !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fall_status: got %h irq=%b expected 00000081 irq=1", d, irq);
    end
  endtask

  task automatic test_clear;
    logic [31:0] d;
    logic        k;
    bus_write(32'h0C, 32'h01);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clear1_irq: got %b expected 1", irq);
    end
    bus_read(32'h0C, d, k);
    total++;
    if (d !== 32'h80) begin
      bad++;
      $display("[TB] FAIL clear1_status: got %h expected 00000080", d);
    end
    bus_write(32'h0C, 32'h80);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clear2_irq: got %b expected 0", irq);
    end
    bus_read(32'h0C, d, k);
    total++;
    if (d !== 32'h00) begin
      bad++;
      $display("[TB] FAIL clear2_status: got %h expected 00000000", d);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic        k;
    bus_write(32'h00, 32'd0);
    bus_write(32'h04, 32'h0C);
    @(posedge clk);
    #1;
    pin_i[2] = 1'b1;
    repeat (SW + 1) @(posedge clk);
    #1;
    bus.addr  = 32'h0C;
    bus.wdata = 32'h04;
    bus.wen   = 1'b1;
    @(posedge clk);
    #1;
    bus.wen = 1'b0;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("[TB] FAIL collide_irq: got %b expected 1", irq);
    end
    bus_read(32'h0C, d, k);
    total++;
    if (d !== 32'h04) begin
      bad++;
      $display("[TB] FAIL collide_status: got %h expected 00000004", d);
    end
    bus_write(32'h0C, 32'h04);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL collide_clear_irq: got %b expected 0", irq);
    end
    @(posedge clk);
    #1;
    pin_i[3] = 1'b1;
    repeat (SW + 1) @(posedge clk);
    #1;
    bus.addr = 32'h0C;
    bus.ren  = 1'b1;
    @(posedge clk);
    #1;
    bus.ren = 1'b0;
    total++;
    if (bus.rdata !== 32'h00 || bus.ack !== 1'b1 || irq !== 1'b1) begin
      bad++;
      $display("[TB] FAIL read_vs_set: got data=%h ack=%b irq=%b expected 0 1 1",
               bus.rdata, bus.ack, irq);
    end
    bus_read(32'h0C, d, k);
    total++;
    if (d !== 32'h08) begin
      bad++;
      $display("[TB] FAIL read_vs_set_after: got %h expected 00000008", d);
    end
    bus_write(32'h0C, 32'h08);
  endtask

  task automatic test_reset_midway;
    logic [31:0] d;
    logic        k;
    bus_write(32'h00, 32'd100);
    @(posedge clk);
    #1;
    pin_i[6] = 1'b1;
    repeat (SW + 40) @(posedge clk);
    #1;
    total++;
    if (gpio_i !== 8'h0D) begin
      bad++;
      $display("[TB] FAIL pending_state: got %h expected 0d", gpio_i);
    end
    rstn = 1'b0;
    #1;
    total++;
    if (gpio_i !== 8'h00 || irq !== 1'b0 || bus.ack !== 1'b0 || bus.rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL async_reset: got gpio=%h irq=%b ack=%b rdata=%h expected all 0",
               gpio_i, irq, bus.ack, bus.rdata);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int e = 1; e <= SW + 1; e++) begin
      @(posedge clk);
      #1;
      total++;
      if (gpio_i !== ((e >= SW + 1) ? 8'h4D : 8'h00)) begin
        bad++;
        $display("[TB] FAIL post_reset_edge%0d: got %h expected %h", e, gpio_i,
                 (e >= SW + 1) ? 8'h4D : 8'h00);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_reset_irq: got %b expected 0", irq);
    end
    bus_read(32'h0C, d, k);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("[TB] FAIL post_reset_status: got %h expected 00000000", d);
    end
    bus_read(32'h00, d, k);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("[TB] FAIL post_reset_deb: got %h expected 00000000", d);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    total     = 0;
    bad       = 0;
    rstn      = 1'b0;
    pin_i     = '0;
    bus.wen   = 1'b0;
    bus.ren   = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    test_reset;
    test_deb0_rise;
    test_glitch_fall;
    test_clear;
    test_back_to_back;
    test_reset_midway;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
